network_interface: RTL and testbench

NETWORK_INTERFACE -- requirements
Module: network_interface

---
 rtl/network_interface.sv | 200 ++++++++++++++++++++
 tb/tb_network_interface.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/network_interface.sv
// Mesh network interface: injection FIFO toward the router, 2-entry ejection skid buffer toward the core.
// Optional packet statistics counters are built only when NI_STATS_EN is defined.
package network_interface_pkg;
    typedef struct packed {
        logic [3:0]  x_dest;
        logic [3:0]  y_dest;
        logic [23:0] payload;
    } packet_t;
endpackage

module network_interface
    import network_interface_pkg::*;
#(
    parameter int X_LOC     = 0,
    parameter int Y_LOC     = 0,
    parameter int INJ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  packet_t     i_core_data,
    input  logic        i_core_val,
    output logic        o_core_ready,
    output packet_t     o_data,
    output logic        o_data_val,
    input  logic        i_en,
    input  packet_t     i_data,
    input  logic        i_data_val,
    output logic        o_en,
    output packet_t     o_core_data,
    output logic        o_core_val,
    input  logic        i_core_en,
    output logic        o_misroute,
    output logic [31:0] o_inj_count,
    output logic [31:0] o_ej_count
);
    localparam int PW = $clog2(INJ_DEPTH);

    localparam logic [1:0] EJ_EMPTY = 2'd0;
    localparam logic [1:0] EJ_ONE   = 2'd1;
    localparam logic [1:0] EJ_TWO   = 2'd2;

    // Held low through reset so both ready outputs rise one edge after release.
    logic live_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    packet_t       mem_q [INJ_DEPTH];

    logic [1:0]    ej_state_q, ej_state_d;
    packet_t       slot0_q, slot0_d;
    packet_t       slot1_q, slot1_d;
    logic          misroute_q, misroute_d;

    logic push_s, pop_s, full_s, accept_s, deliver_s, wrong_dest_s;

    assign full_s       = (occ_q == (PW+1)'(INJ_DEPTH));
    assign o_core_ready = live_q && !full_s;
    assign o_data_val   = (occ_q != {(PW+1){1'b0}});
    assign o_data       = mem_q[rd_ptr_q];
    assign push_s       = i_core_val && o_core_ready;
    assign pop_s        = o_data_val && i_en;

    assign o_en         = live_q && (ej_state_q != EJ_TWO);
    assign o_core_val   = (ej_state_q != EJ_EMPTY);
    assign o_core_data  = slot0_q;
    assign o_misroute   = misroute_q;
    assign accept_s     = i_data_val && o_en;
    assign deliver_s    = o_core_val && i_core_en;
    assign wrong_dest_s = (i_data.x_dest != 4'(X_LOC)) || (i_data.y_dest != 4'(Y_LOC));

    // Injection FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            occ_d = occ_q + {{PW{1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - {{PW{1'b0}}, 1'b1};
        end else begin
            occ_d = occ_q;
        end
    end

    // Ejection skid buffer: slot0 is always the oldest packet.
    always_comb begin
        ej_state_d = ej_state_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        case (ej_state_q)
            EJ_EMPTY: begin
                if (accept_s) begin
                    slot0_d    = i_data;
                    ej_state_d = EJ_ONE;
                end else begin
                    ej_state_d = EJ_EMPTY;
                end
            end
            EJ_ONE: begin
                if (accept_s && deliver_s) begin
                    slot0_d    = i_data;
                    ej_state_d = EJ_ONE;
                end else if (accept_s) begin
                    slot1_d    = i_data;
                    ej_state_d = EJ_TWO;
                end else if (deliver_s) begin
                    ej_state_d = EJ_EMPTY;
                end else begin
                    ej_state_d = EJ_ONE;
                end
            end
            EJ_TWO: begin
                if (deliver_s) begin
                    slot0_d    = slot1_q;
                    ej_state_d = EJ_ONE;
                end else begin
                    ej_state_d = EJ_TWO;
                end
            end
            default: begin
                ej_state_d = EJ_EMPTY;
            end
        endcase
    end

    // Sticky misroute detection on every accepted packet.
    always_comb begin
        if (accept_s && wrong_dest_s) begin
            misroute_d = 1'b1;
        end else begin
            misroute_d = misroute_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q     <= 1'b0;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            occ_q      <= {(PW+1){1'b0}};
            ej_state_q <= EJ_EMPTY;
            misroute_q <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            ej_state_q <= ej_state_d;
            misroute_q <= misroute_d;
        end
    end

    // Packet storage carries no reset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_core_data;
        end
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

`ifdef NI_STATS_EN
    logic [31:0] inj_cnt_q;
    logic [31:0] ej_cnt_q;

    // Saturating transfer counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_cnt_q <= 32'd0;
            ej_cnt_q  <= 32'd0;
        end else begin
            if (pop_s && (inj_cnt_q != 32'hFFFF_FFFF)) begin
                inj_cnt_q <= inj_cnt_q + 32'd1;
            end
            if (accept_s && (ej_cnt_q != 32'hFFFF_FFFF)) begin
                ej_cnt_q <= ej_cnt_q + 32'd1;
            end
        end
    end

    assign o_inj_count = inj_cnt_q;
    assign o_ej_count  = ej_cnt_q;
`else
    assign o_inj_count = 32'd0;
    assign o_ej_count  = 32'd0;
`endif

endmodule

// File: tb/tb_network_interface.sv
// Scoreboard bench for network_interface (X_LOC=1, Y_LOC=2, INJ_DEPTH=4).
module tb_network_interface;
    import network_interface_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    packet_t     i_core_data, o_data, i_data, o_core_data;
    logic        i_core_val, o_core_ready, o_data_val, i_en;
    logic        i_data_val, o_en, o_core_val, i_core_en, o_misroute;
    logic [31:0] o_inj_count, o_ej_count;

    network_interface #(.X_LOC(1), .Y_LOC(2), .INJ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .i_core_data(i_core_data), .i_core_val(i_core_val), .o_core_ready(o_core_ready),
        .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en),
        .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
        .o_core_data(o_core_data), .o_core_val(o_core_val), .i_core_en(i_core_en),
        .o_misroute(o_misroute), .o_inj_count(o_inj_count), .o_ej_count(o_ej_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    packet_t     inj_q[$];
    packet_t     ej_q[$];
    logic        rdy_m = 1'b0;
    logic        mis_m = 1'b0;
    logic [31:0] inj_cnt_m = 32'd0;
    logic [31:0] ej_cnt_m  = 32'd0;
    int          seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic packet_t mk(input logic [3:0] x, input logic [3:0] y);
        packet_t p;
        seq++;
        p.x_dest  = x;
        p.y_dest  = y;
        p.payload = 24'(seq);
        return p;
    endfunction

    // Scoreboard: compare against the model, then advance it with the handshakes of the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_core_ready", 64'(o_core_ready), 64'd0);
            check("rst_data_val", 64'(o_data_val), 64'd0);
            check("rst_en", 64'(o_en), 64'd0);
            check("rst_core_val", 64'(o_core_val), 64'd0);
            check("rst_misroute", 64'(o_misroute), 64'd0);
            check("rst_inj_cnt", 64'(o_inj_count), 64'd0);
            check("rst_ej_cnt", 64'(o_ej_count), 64'd0);
            inj_q.delete();
            ej_q.delete();
            mis_m = 1'b0;
            rdy_m = 1'b0;
            inj_cnt_m = 32'd0;
            ej_cnt_m  = 32'd0;
        end else begin
            logic push_m, pop_m, acc_m, del_m;
            check("core_ready", 64'(o_core_ready), 64'(rdy_m && inj_q.size() < 4));
            check("data_val", 64'(o_data_val), 64'(inj_q.size() != 0));
            if (inj_q.size() != 0) check("o_data", 64'(o_data), 64'(inj_q[0]));
            check("o_en", 64'(o_en), 64'(rdy_m && ej_q.size() < 2));
            check("core_val", 64'(o_core_val), 64'(ej_q.size() != 0));
            if (ej_q.size() != 0) check("core_data", 64'(o_core_data), 64'(ej_q[0]));
            check("misroute", 64'(o_misroute), 64'(mis_m));
            check("inj_count", 64'(o_inj_count), 64'(inj_cnt_m));
            check("ej_count", 64'(o_ej_count), 64'(ej_cnt_m));

            push_m = i_core_val && rdy_m && (inj_q.size() < 4);
            pop_m  = i_en && (inj_q.size() != 0);
            acc_m  = i_data_val && rdy_m && (ej_q.size() < 2);
            del_m  = i_core_en && (ej_q.size() != 0);
            if (pop_m) begin
                void'(inj_q.pop_front());
`ifdef NI_STATS_EN
                if (inj_cnt_m != 32'hFFFF_FFFF) inj_cnt_m = inj_cnt_m + 32'd1;
`endif
            end
            if (push_m) inj_q.push_back(i_core_data);
            if (del_m) void'(ej_q.pop_front());
            if (acc_m) begin
                ej_q.push_back(i_data);
                if (i_data.x_dest != 4'd1 || i_data.y_dest != 4'd2) mis_m = 1'b1;
`ifdef NI_STATS_EN
                if (ej_cnt_m != 32'hFFFF_FFFF) ej_cnt_m = ej_cnt_m + 32'd1;
`endif
            end
            rdy_m = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_core_val = 1'b0;
        i_en       = 1'b0;
        i_data_val = 1'b0;
        i_core_en  = 1'b0;
        i_core_data = '0;
        i_data      = '0;
    endtask

    // Present a packet to the ejection side until it is accepted or the budget runs out.
    task automatic eject_send(input packet_t p, input int budget);
        logic acc;
        acc = 1'b0;
        i_data     = p;
        i_data_val = 1'b1;
        for (int k = 0; k < budget && !acc; k++) begin
            @(negedge clk);
            acc = o_en;
            tick();
        end
        check("eject_accept_timeout", 64'(acc), 64'd1);
        i_data_val = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset();

        // Fill the injection FIFO with the router stalled.
        i_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_core_data = mk(4'd1, 4'd2);
            i_core_val  = 1'b1;
            tick();
        end
        i_core_val = 1'b0;
        repeat (3) tick();

        // Full FIFO with simultaneous offer and drain.
        for (int k = 0; k < 8; k++) begin
            i_core_data = mk(4'd3, 4'd0);
            i_core_val  = 1'b1;
            i_en        = 1'b1;
            tick();
        end
        i_core_val = 1'b0;
        repeat (6) tick();
        i_en = 1'b0;

        // Random injection traffic.
        for (int k = 0; k < 40; k++) begin
            i_core_data = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            i_core_val  = 1'($urandom_range(0, 1));
            i_en        = 1'($urandom_range(0, 1));
            tick();
        end
        i_core_val = 1'b0;
        i_en = 1'b1;
        repeat (6) tick();
        i_en = 1'b0;

        // Ejection back-pressure: two accepted, third held off until the core drains.
        i_core_en = 1'b0;
        eject_send(mk(4'd1, 4'd2), 4);
        eject_send(mk(4'd1, 4'd2), 4);
        i_data     = mk(4'd1, 4'd2);
        i_data_val = 1'b1;
        repeat (4) tick();
        i_core_en = 1'b1;
        eject_send(i_data, 6);
        repeat (4) tick();

        // Misrouted packet is flagged, still delivered, and the flag sticks.
        eject_send(mk(4'd1, 4'd3), 4);
        repeat (3) tick();
        eject_send(mk(4'd1, 4'd2), 4);
        repeat (3) tick();

        // Reset while ejection holds two and injection holds three.
        i_core_en = 1'b0;
        eject_send(mk(4'd1, 4'd2), 4);
        eject_send(mk(4'd1, 4'd2), 4);
        for (int k = 0; k < 3; k++) begin
            i_core_data = mk(4'd0, 4'd0);
            i_core_val  = 1'b1;
            tick();
        end
        i_core_val = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("async_data_val", 64'(o_data_val), 64'd0);
        check("async_core_val", 64'(o_core_val), 64'd0);
        check("async_core_ready", 64'(o_core_ready), 64'd0);
        check("async_en", 64'(o_en), 64'd0);
        check("async_misroute", 64'(o_misroute), 64'd0);
        idle_inputs();
        repeat (2) tick();
        reset = 1'b0;
        i_core_en = 1'b1;
        i_en = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
